// File: rtl/imem_program_loader.sv
// imem_program_loader
//   Packs instruction field bundles into 32-bit ISA words and writes them to
//   consecutive instruction-memory addresses, holding the processor in reset
//   until the program load completes.
// Ports:
//   clock, resetn            system clock, asynchronous active-low reset
//   start                    1-cycle pulse; from DONE restarts a load at addr 0
//   in_valid / in_ready      field-bundle handshake
//   in_opcode .. in_target   instruction fields
//   in_last                  bundle is the final instruction of the program
//   imem_we/addr/wdata       instruction-memory write port
//   cpu_resetn, done         processor reset release and load-finished flag
//   err_illegal              sticky: unknown opcode received
//   err_overflow             sticky: DEPTH words written without in_last
//   word_count               words written in the current load
module imem_program_loader #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DEPTH  = 4096
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_shamt,
    input  logic [4:0]        in_aluop,
    input  logic [16:0]       in_imm,
    input  logic [26:0]       in_target,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_resetn,
    output logic              done,
    output logic              err_illegal,
    output logic              err_overflow,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {StIdle, StWrite, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              last_q, last_d;
    logic              ill_q, ill_d;
    logic              ovf_q, ovf_d;
    logic [ADDR_W:0]   count_q, count_d;

    logic [31:0] enc_word;
    logic        enc_legal;
    logic        accept;

    // ISA encoder: opcode in [31:27], unused bits zero.
    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b1;
        case (in_opcode)
            5'b00000: enc_word = {in_opcode, in_rd, in_rs, in_rt, in_shamt, in_aluop, 2'b00};
            5'b00101, 5'b00010, 5'b00110, 5'b00111, 5'b01000:
                enc_word = {in_opcode, in_rd, in_rs, in_imm};
            5'b00001, 5'b00011, 5'b10101, 5'b10110:
                enc_word = {in_opcode, in_target};
            5'b00100: enc_word = {in_opcode, in_rd, 22'd0};
            default:  enc_legal = 1'b0;
        endcase
    end

    assign in_ready = resetn && (state_q == StIdle);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        last_d  = last_q;
        ill_d   = ill_q;
        ovf_d   = ovf_q;
        count_d = count_q;

        imem_we    = 1'b0;
        done       = 1'b0;
        cpu_resetn = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (enc_legal) begin
                        addr_d  = count_q[ADDR_W-1:0];
                        wdata_d = enc_word;
                        last_d  = in_last;
                        state_d = StWrite;
                    end else begin
                        // Illegal opcode: no write; in_last still ends the load.
                        ill_d = 1'b1;
                        if (in_last) state_d = StDone;
                    end
                end
            end
            StWrite: begin
                imem_we = 1'b1;
                count_d = count_q + 1'b1;
                if (last_q) begin
                    state_d = StDone;
                end else if (addr_q == LastAddr) begin
                    state_d = StDone;
                    ovf_d   = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            StDone: begin
                // start drops done/cpu_resetn in the same cycle it is seen.
                done       = !start;
                cpu_resetn = !start;
                if (start) begin
                    count_d = '0;
                    ill_d   = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            last_q  <= 1'b0;
            ill_q   <= 1'b0;
            ovf_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            last_q  <= last_d;
            ill_q   <= ill_d;
            ovf_q   <= ovf_d;
            count_q <= count_d;
        end
    end

    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign err_illegal  = ill_q;
    assign err_overflow = ovf_q;
    assign word_count   = count_q;

endmodule

// File: tb/tb_imem_program_loader.sv
module tb_imem_program_loader;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DEPTH  = 10;

    logic              clock = 1'b0;
    logic              resetn = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [4:0]        in_opcode = '0, in_rd = '0, in_rs = '0, in_rt = '0;
    logic [4:0]        in_shamt = '0, in_aluop = '0;
    logic [16:0]       in_imm = '0;
    logic [26:0]       in_target = '0;
    logic              in_last = 1'b0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_resetn, done, err_illegal, err_overflow;
    logic [ADDR_W:0]   word_count;

    imem_program_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clock(clock), .resetn(resetn), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt),
        .in_shamt(in_shamt), .in_aluop(in_aluop), .in_imm(in_imm),
        .in_target(in_target), .in_last(in_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_resetn(cpu_resetn), .done(done), .err_illegal(err_illegal),
        .err_overflow(err_overflow), .word_count(word_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [4:0]  op, rd, rs, rt, shamt, aluop;
        logic [16:0] imm;
        logic [26:0] target;
        bit          last;
    } bundle_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        time               t;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model state
    int m_count = 0;
    bit m_done = 0, m_ill = 0, m_ovf = 0;

    logic [4:0] legal_ops [11] = '{5'd0, 5'd5, 5'd2, 5'd6, 5'd7, 5'd8, 5'd1, 5'd3,
                                   5'd21, 5'd22, 5'd4};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input bundle_t b, output bit legal);
        logic [31:0] w;
        legal = 1;
        w = 32'(b.op) << 27;
        if (b.op == 0)
            w = w + (32'(b.rd) << 22) + (32'(b.rs) << 17) + (32'(b.rt) << 12)
                  + (32'(b.shamt) << 7) + (32'(b.aluop) << 2);
        else if (b.op == 5 || b.op == 2 || b.op == 6 || b.op == 7 || b.op == 8)
            w = w + (32'(b.rd) << 22) + (32'(b.rs) << 17) + 32'(b.imm);
        else if (b.op == 1 || b.op == 3 || b.op == 21 || b.op == 22)
            w = w + 32'(b.target);
        else if (b.op == 4)
            w = w + (32'(b.rd) << 22);
        else
            legal = 0;
        return w;
    endfunction

    task automatic model_reset();
        m_count = 0; m_done = 0; m_ill = 0; m_ovf = 0;
    endtask

    task automatic model_accept(input bundle_t b, input time t);
        bit lg;
        logic [31:0] w;
        w = model_word(b, lg);
        if (lg) begin
            sb.push_back('{addr: ADDR_W'(m_count), data: w, t: t});
            m_count++;
            if (b.last) m_done = 1;
            else if (m_count == DEPTH) begin m_done = 1; m_ovf = 1; end
        end else begin
            m_ill = 1;
            if (b.last) m_done = 1;
        end
    endtask

    // Monitor: every write must match the oldest expected word, one cycle after accept.
    always @(negedge clock) begin
        exp_t e;
        if (resetn && imem_we) begin
            if (sb.size() == 0) begin
                check("unexpected_write", 32'(imem_addr), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("wr_addr", 32'(imem_addr), 32'(e.addr));
                check("wr_data", imem_wdata, e.data);
                check("wr_latency", 32'($time - e.t), 32'd5);
            end
        end
    end

    function automatic bundle_t mk(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs,
                                   input logic [4:0] rt, input logic [16:0] imm,
                                   input logic [26:0] tgt, input bit last);
        bundle_t b;
        b.op = op; b.rd = rd; b.rs = rs; b.rt = rt; b.shamt = 5'd0; b.aluop = 5'd0;
        b.imm = imm; b.target = tgt; b.last = last;
        return b;
    endfunction

    function automatic bundle_t rand_bundle(input bit last);
        bundle_t b;
        if ($urandom_range(0, 9) < 8) b.op = legal_ops[$urandom_range(0, 10)];
        else b.op = 5'($urandom_range(0, 31));
        b.rd = 5'($urandom); b.rs = 5'($urandom); b.rt = 5'($urandom);
        b.shamt = 5'($urandom); b.aluop = 5'($urandom);
        b.imm = 17'($urandom); b.target = 27'($urandom);
        b.last = last;
        return b;
    endfunction

    task automatic send(input bundle_t b, input int tries, output bit acc);
        @(negedge clock);
        in_opcode = b.op; in_rd = b.rd; in_rs = b.rs; in_rt = b.rt;
        in_shamt = b.shamt; in_aluop = b.aluop; in_imm = b.imm;
        in_target = b.target; in_last = b.last; in_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < tries; i++) begin
            if (in_ready === 1'b1) begin
                @(posedge clock);
                acc = 1;
                model_accept(b, $time);
                break;
            end
            @(negedge clock);
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic send_ok(input bundle_t b);
        bit acc;
        send(b, 20, acc);
        check("accept", 32'(acc), 32'd1);
    endtask

    task automatic run_random(input int n, input bit use_last);
        for (int i = 0; i < n && !m_done; i++) begin
            send_ok(rand_bundle(use_last && (i == n - 1)));
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end
    endtask

    task automatic check_done();
        for (int i = 0; i < 10 && done !== 1'b1; i++) @(negedge clock);
        @(negedge clock);
        #1;
        check("done", 32'(done), 32'd1);
        check("cpu_resetn_done", 32'(cpu_resetn), 32'd1);
        check("in_ready_done", 32'(in_ready), 32'd0);
        check("we_done", 32'(imem_we), 32'd0);
        check("word_count", 32'(word_count), 32'(m_count));
        check("err_illegal", 32'(err_illegal), 32'(m_ill));
        check("err_overflow", 32'(err_overflow), 32'(m_ovf));
        check("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic restart();
        @(negedge clock);
        start = 1'b1;
        #1;
        check("done_on_start", 32'(done), 32'd0);
        check("cpu_resetn_on_start", 32'(cpu_resetn), 32'd0);
        @(posedge clock);
        #1 start = 1'b0;
        model_reset();
        @(negedge clock);
        #1;
        check("restart_count", 32'(word_count), 32'd0);
        check("restart_errs", {30'd0, err_illegal, err_overflow}, 32'd0);
        check("restart_ready", 32'(in_ready), 32'd1);
        check("restart_cpu_held", 32'(cpu_resetn), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_we"}, 32'(imem_we), 32'd0);
        check({tag, "_addr"}, 32'(imem_addr), 32'd0);
        check({tag, "_wdata"}, imem_wdata, 32'd0);
        check({tag, "_flags"}, {28'd0, cpu_resetn, done, err_illegal, err_overflow}, 32'd0);
        check({tag, "_count"}, 32'(word_count), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        bit acc;
        #2 check_all_zero("reset");
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        #1;
        check("ready_after_reset", 32'(in_ready), 32'd1);
        check("cpu_held_after_reset", 32'(cpu_resetn), 32'd0);

        // Directed: addi, R, j, jr(last)
        send_ok(mk(5'd5, 5'd3, 5'd1, 5'd0, 17'd5, 27'd0, 0));
        send_ok(mk(5'd0, 5'd1, 5'd2, 5'd3, 17'd0, 27'd0, 0));
        send_ok(mk(5'd1, 5'd0, 5'd0, 5'd0, 17'd0, 27'h10, 0));
        send_ok(mk(5'd4, 5'd31, 5'd0, 5'd0, 17'd0, 27'd0, 1));
        check_done();
        restart();

        // Directed: illegal opcode then setx(last)
        send_ok(mk(5'd9, 5'd0, 5'd0, 5'd0, 17'd0, 27'd0, 0));
        send_ok(mk(5'd21, 5'd0, 5'd0, 5'd0, 17'd0, 27'd7, 1));
        check_done();
        restart();

        // Random programs
        for (int p = 0; p < 6; p++) begin
            run_random($urandom_range(1, 8), 1);
            check_done();
            restart();
        end

        // Overflow: no in_last; the bundle after overflow must not be accepted
        run_random(DEPTH + 5, 0);
        check_done();
        send(rand_bundle(0), 4, acc);
        check("overflow_extra_rejected", 32'(acc), 32'd0);
        restart();

        // Reset during WRITE after a couple of words
        send_ok(mk(5'd5, 5'd1, 5'd2, 5'd0, 17'd9, 27'd0, 0));
        send_ok(mk(5'd9, 5'd0, 5'd0, 5'd0, 17'd0, 27'd0, 0));
        send_ok(mk(5'd8, 5'd4, 5'd5, 5'd0, 17'd3, 27'd0, 0));
        #1 resetn = 1'b0;
        sb.delete();
        model_reset();
        #1 check_all_zero("midreset");
        @(negedge clock);
        resetn = 1'b1;
        run_random(5, 1);
        check_done();
        restart();
        run_random(4, 1);
        check_done();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
